// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: retires one multiplier bit per clock through a
// single WIDTH-bit adder, with valid/ready handshakes and run-time signed mode.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mag_a;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // Magnitudes of the most-negative value still fit unsigned in WIDTH bits.
  assign abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  // acc upper half is the partial product, lower half the unretired multiplier bits.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  assign acc_next = {sum, acc[WIDTH-1:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag_a <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a <= abs_a;
            acc   <= {{WIDTH{1'b0}}, abs_b};
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= CW'(WIDTH);
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            p     <= neg ? -acc_next : acc_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
